// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, access size
// codes, error codes, FSM state encoding and the latched request payload.
package mem_access_unit_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned F3_W   = 3;
   localparam int unsigned SIZE_W = 3;
   localparam int unsigned ERR_W  = 2;
   localparam int unsigned TAG_W  = 5;

   // RV32I load/store width encodings
   localparam logic [F3_W-1:0] F3_BYTE   = 3'b000;
   localparam logic [F3_W-1:0] F3_HALF   = 3'b001;
   localparam logic [F3_W-1:0] F3_WORD   = 3'b010;
   localparam logic [F3_W-1:0] F3_BYTE_U = 3'b100;
   localparam logic [F3_W-1:0] F3_HALF_U = 3'b101;

   // RAM access size codes, in bytes
   localparam logic [SIZE_W-1:0] SZ_B = 3'd1;
   localparam logic [SIZE_W-1:0] SZ_H = 3'd2;
   localparam logic [SIZE_W-1:0] SZ_W = 3'd4;

   typedef enum logic [ERR_W-1:0] {
      ERR_OK       = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_FAULT    = 2'd2,
      ERR_ILLEGAL  = 2'd3
   } err_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Request fields kept for the duration of one transaction
   typedef struct packed {
      logic              we;
      logic [F3_W-1:0]   funct3;
      logic [ADDR_W-1:0] addr;
      logic [TAG_W-1:0]  rd;
   } req_t;

   // Byte count from the low funct3 bits; 2'b11 is illegal and never reaches the RAM
   function automatic logic [SIZE_W-1:0] size_of(input logic [F3_W-1:0] funct3);
      logic [SIZE_W-1:0] sz;
      case (funct3[1:0])
         2'b00:   sz = SZ_B;
         2'b01:   sz = SZ_H;
         default: sz = SZ_W;
      endcase
      return sz;
   endfunction

   // Clear the bytes above the access size
   function automatic logic [XLEN-1:0] mask_to_size(input logic [XLEN-1:0] data,
                                                    input logic [SIZE_W-1:0] size);
      logic [XLEN-1:0] m;
      case (size)
         SZ_B:    m = {24'h0, data[7:0]};
         SZ_H:    m = {16'h0, data[15:0]};
         default: m = data;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle around the load/store unit: request and response handshakes from
// the execute stage plus the split read/write ports to the data RAM.
// slave  : the load/store unit itself
// master : the surrounding environment (execute stage + data RAM)
interface mem_access_unit_if;
   import mem_access_unit_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [F3_W-1:0]   req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic [TAG_W-1:0]  req_rd;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [XLEN-1:0]   rsp_rdata;
   logic [TAG_W-1:0]  rsp_rd;
   logic [ERR_W-1:0]  rsp_err;

   logic [ADDR_W-1:0] rd_addr_o;
   logic              rd_en_o;
   logic [SIZE_W-1:0] rd_size_o;
   logic [XLEN-1:0]   rd_data_i;

   logic [ADDR_W-1:0] wd_addr_o;
   logic              wd_en_o;
   logic [SIZE_W-1:0] wd_size_o;
   logic [XLEN-1:0]   wd_data_o;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_rd, rsp_err,
      input  rsp_ready,
      output rd_addr_o, rd_en_o, rd_size_o,
      input  rd_data_i,
      output wd_addr_o, wd_en_o, wd_size_o, wd_data_o
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_rd, rsp_err,
      output rsp_ready,
      input  rd_addr_o, rd_en_o, rd_size_o,
      output rd_data_i,
      input  wd_addr_o, wd_en_o, wd_size_o, wd_data_o
   );

endinterface

// File: rtl/mem_access_unit_load_ext.sv
// load_ext: sign/zero extension of LSB-aligned raw load data by RV32I funct3.
// Ports: funct3 (width code), raw (32-bit LSB-aligned data), result_c (extended).
// Purely combinational so it can be shared with the fetch path.
module load_ext
   import mem_access_unit_pkg::*;
(
   input  logic [F3_W-1:0] funct3,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] result_c
);

   // Extension select; word and unknown codes pass through
   always_comb begin
      result_c = raw;
      case (funct3)
         F3_BYTE:   result_c = {{24{raw[7]}}, raw[7:0]};
         F3_HALF:   result_c = {{16{raw[15]}}, raw[15:0]};
         F3_BYTE_U: result_c = {24'h0, raw[7:0]};
         F3_HALF_U: result_c = {16'h0, raw[15:0]};
         default:   result_c = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator for the data RAM.
// Accepts a request, checks funct3 legality, alignment and range, performs one
// RAM cycle (read or write) and returns an extended load result or store
// completion on the response channel.
// Ports: clk, rst (synchronous, active low), bus (mem_access_unit_if.slave):
//   req_*  request handshake from execute, rsp_* response handshake,
//   rd_*   RAM read port, wd_* RAM write port.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned MEM_BYTES   = 8192,
   parameter bit          CHECK_ALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_unit_if.slave  bus
);

   state_e            state_q, state_d;
   req_t              req_q;
   logic [SIZE_W-1:0] size_q;
   logic [XLEN-1:0]   wd_data_q;
   logic              rd_go_q, wr_go_q;

   logic              rsp_valid_q;
   logic [XLEN-1:0]   rsp_rdata_q;
   logic [TAG_W-1:0]  rsp_rd_q;
   logic [ERR_W-1:0]  rsp_err_q;

   logic              accept_c;
   logic [SIZE_W-1:0] req_size_c;
   logic              illegal_c, misalign_c, fault_c;
   logic [ADDR_W:0]   end_addr_c;
   err_e              req_err_c;
   logic [XLEN-1:0]   ext_c;

   // Request classification; the end address is one bit wider so it cannot wrap
   always_comb begin
      req_size_c = size_of(bus.req_funct3);
      illegal_c  = (bus.req_funct3 inside {3'b011, 3'b110, 3'b111})
                   || (bus.req_we && bus.req_funct3[2]);
      misalign_c = CHECK_ALIGN && (((req_size_c == SZ_H) && bus.req_addr[0])
                   || ((req_size_c == SZ_W) && (bus.req_addr[1:0] != 2'b00)));
      end_addr_c = {1'b0, bus.req_addr} + (ADDR_W+1)'(req_size_c);
      fault_c    = end_addr_c > (ADDR_W+1)'(MEM_BYTES);
      if (illegal_c)       req_err_c = ERR_ILLEGAL;
      else if (misalign_c) req_err_c = ERR_MISALIGN;
      else if (fault_c)    req_err_c = ERR_FAULT;
      else                 req_err_c = ERR_OK;
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               accept_c = 1'b1;
               state_d  = (req_err_c != ERR_OK) ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   load_ext u_load_ext (
      .funct3   (req_q.funct3),
      .raw      (bus.rd_data_i),
      .result_c (ext_c)
   );

   // Request, RAM-port and response registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         req_q       <= '0;
         size_q      <= '0;
         wd_data_q   <= '0;
         rd_go_q     <= 1'b0;
         wr_go_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_rd_q    <= '0;
         rsp_err_q   <= '0;
      end else begin
         // RAM enables are one-cycle pulses set only for error-free requests
         rd_go_q <= 1'b0;
         wr_go_q <= 1'b0;
         if (accept_c) begin
            req_q.we     <= bus.req_we;
            req_q.funct3 <= bus.req_funct3;
            req_q.addr   <= bus.req_addr;
            req_q.rd     <= bus.req_rd;
            size_q       <= req_size_c;
            wd_data_q    <= mask_to_size(bus.req_wdata, req_size_c);
            if (req_err_c == ERR_OK) begin
               rd_go_q <= ~bus.req_we;
               wr_go_q <= bus.req_we;
            end else begin
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= '0;
               rsp_rd_q    <= bus.req_rd;
               rsp_err_q   <= req_err_c;
            end
         end
         if (state_q == ST_ACCESS) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= req_q.we ? '0 : ext_c;
            rsp_rd_q    <= req_q.rd;
            rsp_err_q   <= ERR_OK;
         end
         if ((state_q == ST_RESP) && bus.rsp_ready) rsp_valid_q <= 1'b0;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_rd    = rsp_rd_q;
   assign bus.rsp_err   = rsp_err_q;

   // Enables are gated by reset so a store caught mid-access never writes
   assign bus.rd_en_o   = rd_go_q & rst;
   assign bus.wd_en_o   = wr_go_q & rst;
   assign bus.rd_addr_o = req_q.addr;
   assign bus.rd_size_o = size_q;
   assign bus.wd_addr_o = req_q.addr;
   assign bus.wd_size_o = size_q;
   assign bus.wd_data_o = wd_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array data RAM model.
module tb_mem_access_unit;

   logic clk;
   logic rst;
   logic mem_clr;

   logic [7:0]  mem [8192];
   logic [31:0] rdata_m;
   int          wr_cnt;
   int          rd_cnt;
   int          n_vec;
   int          n_miss;

   mem_access_unit_if bus ();

   mem_access_unit #(
      .MEM_BYTES   (8192),
      .CHECK_ALIGN (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational RAM read, zero-filled above the access size
   always_comb begin
      rdata_m = '0;
      for (int i = 0; i < 4; i++)
         if (i < int'(bus.rd_size_o))
            rdata_m[8*i +: 8] = mem[13'(bus.rd_addr_o + 32'(i))];
   end
   assign bus.rd_data_i = rdata_m;

   // RAM write port and enable-cycle counters
   always @(posedge clk) begin
      if (mem_clr) begin
         foreach (mem[i]) mem[i] <= 8'h00;
      end else if (bus.wd_en_o) begin
         for (int i = 0; i < 4; i++)
            if (i < int'(bus.wd_size_o))
               mem[13'(bus.wd_addr_o + 32'(i))] <= bus.wd_data_o[8*i +: 8];
      end
      if (bus.wd_en_o) wr_cnt <= wr_cnt + 1;
      if (bus.rd_en_o) rd_cnt <= rd_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      n_vec++;
      if (got !== exp_v) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp_v);
      end
   endtask

   // One full transaction, starting and ending at a negedge
   task automatic run(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] rd, input logic [1:0] exp_err,
                      input logic [31:0] exp_rdata, input logic [31:0] exp_wd,
                      input logic [2:0] exp_sz, input int stall);
      int wr0, rd0, exp_wr, exp_rd;
      wr0    = wr_cnt;
      rd0    = rd_cnt;
      exp_wr = (we && exp_err == 2'd0) ? 1 : 0;
      exp_rd = (!we && exp_err == 2'd0) ? 1 : 0;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_rd     = rd;
      check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (exp_err != 2'd0) begin
         check({tag, "/rsp_valid_n1"}, 32'(bus.rsp_valid), 32'd1);
         check({tag, "/no_ram_en"}, 32'({bus.rd_en_o, bus.wd_en_o}), 32'd0);
      end else begin
         check({tag, "/rsp_valid_n1"}, 32'(bus.rsp_valid), 32'd0);
         check({tag, "/rd_en"}, 32'(bus.rd_en_o), 32'(!we));
         check({tag, "/wd_en"}, 32'(bus.wd_en_o), 32'(we));
         check({tag, "/size"}, 32'(we ? bus.wd_size_o : bus.rd_size_o), 32'(exp_sz));
         check({tag, "/ram_addr"}, we ? bus.wd_addr_o : bus.rd_addr_o, addr);
         if (we) check({tag, "/wd_data"}, bus.wd_data_o, exp_wd);
         @(negedge clk);
         check({tag, "/rsp_valid_n2"}, 32'(bus.rsp_valid), 32'd1);
      end
      check({tag, "/rdata"}, bus.rsp_rdata, exp_rdata);
      check({tag, "/err"}, 32'(bus.rsp_err), 32'(exp_err));
      check({tag, "/rd"}, 32'(bus.rsp_rd), 32'(rd));
      check({tag, "/busy"}, 32'(bus.req_ready), 32'd0);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check({tag, "/stall_valid"}, 32'(bus.rsp_valid), 32'd1);
         check({tag, "/stall_rdata"}, bus.rsp_rdata, exp_rdata);
         check({tag, "/stall_busy"}, 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check({tag, "/rsp_done"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "/idle"}, 32'(bus.req_ready), 32'd1);
      check({tag, "/wr_cycles"}, 32'(wr_cnt - wr0), 32'(exp_wr));
      check({tag, "/rd_cycles"}, 32'(rd_cnt - rd0), 32'(exp_rd));
   endtask

   initial begin
      n_vec          = 0;
      n_miss         = 0;
      wr_cnt         = 0;
      rd_cnt         = 0;
      mem_clr        = 1'b1;
      rst            = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_rd     = '0;
      bus.rsp_ready  = 1'b0;
      repeat (3) @(negedge clk);
      mem_clr = 1'b0;
      check("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst/rsp_rd", 32'(bus.rsp_rd), 32'd0);
      check("rst/rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst/req_ready", 32'(bus.req_ready), 32'd1);
      check("rst/ram_en", 32'({bus.rd_en_o, bus.wd_en_o}), 32'd0);
      check("rst/ram_addr", bus.wd_addr_o, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      //   tag           we  f3      addr           wdata          rd     err   rdata          wd             sz    stall
      run("sb_0x10",    1, 3'b000, 32'h0000_0010, 32'h0000_0080, 5'd1,  2'd0, 32'h0,         32'h0000_0080, 3'd1, 0);
      run("lb_0x10",    0, 3'b000, 32'h0000_0010, 32'h0,         5'd5,  2'd0, 32'hFFFF_FF80, 32'h0,         3'd1, 0);
      run("lbu_0x10",   0, 3'b100, 32'h0000_0010, 32'h0,         5'd6,  2'd0, 32'h0000_0080, 32'h0,         3'd1, 0);
      run("sw_0x20",    1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 5'd2,  2'd0, 32'h0,         32'hDEAD_BEEF, 3'd4, 0);
      run("lhu_0x22",   0, 3'b101, 32'h0000_0022, 32'h0,         5'd7,  2'd0, 32'h0000_DEAD, 32'h0,         3'd2, 0);
      run("lh_0x20",    0, 3'b001, 32'h0000_0020, 32'h0,         5'd8,  2'd0, 32'hFFFF_BEEF, 32'h0,         3'd2, 0);
      run("lw_0x20",    0, 3'b010, 32'h0000_0020, 32'h0,         5'd9,  2'd0, 32'hDEAD_BEEF, 32'h0,         3'd4, 0);
      run("sb_mask",    1, 3'b000, 32'h0000_0061, 32'h1234_56A5, 5'd3,  2'd0, 32'h0,         32'h0000_00A5, 3'd1, 0);
      run("lb_0x61",    0, 3'b000, 32'h0000_0061, 32'h0,         5'd10, 2'd0, 32'hFFFF_FFA5, 32'h0,         3'd1, 0);
      run("lbu_0x62",   0, 3'b100, 32'h0000_0062, 32'h0,         5'd11, 2'd0, 32'h0,         32'h0,         3'd1, 0);
      run("sh_misal",   1, 3'b001, 32'h0000_0021, 32'h0000_5555, 5'd12, 2'd1, 32'h0,         32'h0,         3'd2, 0);
      check("sh_misal/mem21", 32'(mem[13'h21]), 32'hBE);
      check("sh_misal/mem22", 32'(mem[13'h22]), 32'hAD);
      run("lw_misal",   0, 3'b010, 32'h0000_1FFE, 32'h0,         5'd13, 2'd1, 32'h0,         32'h0,         3'd4, 0);
      run("lw_oob",     0, 3'b010, 32'h0000_2000, 32'h0,         5'd14, 2'd2, 32'h0,         32'h0,         3'd4, 0);
      run("lw_nowrap",  0, 3'b010, 32'hFFFF_FFFC, 32'h0,         5'd15, 2'd2, 32'h0,         32'h0,         3'd4, 0);
      run("sw_oob",     1, 3'b010, 32'h0000_2000, 32'h1111_1111, 5'd16, 2'd2, 32'h0,         32'h0,         3'd4, 0);
      run("lw_last",    0, 3'b010, 32'h0000_1FFC, 32'h0,         5'd17, 2'd0, 32'h0,         32'h0,         3'd4, 0);
      run("lb_last",    0, 3'b000, 32'h0000_1FFF, 32'h0,         5'd18, 2'd0, 32'h0,         32'h0,         3'd1, 0);
      run("ill_f3_011", 0, 3'b011, 32'h0000_0000, 32'h0,         5'd19, 2'd3, 32'h0,         32'h0,         3'd4, 0);
      run("ill_f3_111", 0, 3'b111, 32'h0000_0001, 32'h0,         5'd20, 2'd3, 32'h0,         32'h0,         3'd4, 0);
      run("ill_sbu",    1, 3'b100, 32'h0000_0010, 32'h0000_0001, 5'd21, 2'd3, 32'h0,         32'h0,         3'd1, 0);
      run("ill_shu",    1, 3'b101, 32'h0000_3001, 32'h0000_0001, 5'd22, 2'd3, 32'h0,         32'h0,         3'd2, 0);
      check("ill_sbu/mem10", 32'(mem[13'h10]), 32'h80);
      run("sh_0x30",    1, 3'b001, 32'h0000_0030, 32'hFFFF_8001, 5'd23, 2'd0, 32'h0,         32'h0000_8001, 3'd2, 0);
      run("lh_stall",   0, 3'b001, 32'h0000_0030, 32'h0,         5'd24, 2'd0, 32'hFFFF_8001, 32'h0,         3'd2, 5);

      // Store interrupted by reset during its RAM cycle
      begin
         int wr0;
         wr0            = wr_cnt;
         bus.req_valid  = 1'b1;
         bus.req_we     = 1'b1;
         bus.req_funct3 = 3'b010;
         bus.req_addr   = 32'h0000_0040;
         bus.req_wdata  = 32'h1122_3344;
         bus.req_rd     = 5'd25;
         @(posedge clk);
         @(negedge clk);
         bus.req_valid = 1'b0;
         check("rst_st/wd_en_pre", 32'(bus.wd_en_o), 32'd1);
         rst = 1'b0;
         #1;
         check("rst_st/wd_en_gated", 32'(bus.wd_en_o), 32'd0);
         @(negedge clk);
         rst = 1'b1;
         check("rst_st/rsp_valid", 32'(bus.rsp_valid), 32'd0);
         check("rst_st/req_ready", 32'(bus.req_ready), 32'd1);
         check("rst_st/wd_addr", bus.wd_addr_o, 32'd0);
         check("rst_st/wr_cycles", 32'(wr_cnt - wr0), 32'd0);
         check("rst_st/mem40", {mem[13'h43], mem[13'h42], mem[13'h41], mem[13'h40]}, 32'h0);
      end

      run("lw_post_rst", 0, 3'b010, 32'h0000_0020, 32'h0,        5'd26, 2'd0, 32'hDEAD_BEEF, 32'h0,         3'd4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

endmodule
